m_port_ultra_hull_collector: RTL and testbench
==============================================

M_PORT_ULTRA_HULL_COLLECTOR -- requirements
Module: m_port_ultra_hull_collector

Interface
REQ-001 Point format SHALL be 16 bits {y[15:8], x[7:0]}; hull/cloud buses SHALL pack point k at bits [16k+15:16k].
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 collectorEnable  input  1  level start request; deassertion releases DONE.
REQ-005 processorDone1..4  input  1 each  completion indications from the four quickhull processors; may be pulses or levels.
REQ-006 convexHull1..4  input  4096 each  per-processor hull points, 256 slots.
REQ-007 convexHullSize1..4  input  9 each  valid point count per hull, 0..256.
REQ-008 mergedCloud  output  16384  concatenated hull points, registered.
REQ-009 mergedCloudSize  output  11  number of valid points in mergedCloud, 0..1024, registered.
REQ-010 collectorDone  output  1  merge complete, registered.

Function
REQ-011 FSM states SHALL be IDLE, WAIT_DONE, COPY, DONE.
REQ-012 IDLE: collectorEnable=1 -> WAIT_DONE next cycle; on that transition mergedCloud, mergedCloudSize, the four sticky done flags and write pointer SHALL clear to 0.
REQ-013 WAIT_DONE: each processorDoneN high SHALL set sticky flag N; when all four flags, OR-ed with current-cycle processorDoneN, are set -> COPY next cycle.
REQ-014 On WAIT_DONE->COPY the four sizes SHALL be latched, each clamped to 256 if greater; hull index h=0, point index p=0.
REQ-015 COPY, per cycle: if p < size[h]: mergedCloud[16*wp +:16] <= convexHull(h+1)[16*p +:16], wp++, p++, mergedCloudSize++.
REQ-016 COPY, per cycle: if p == size[h] and h<3: h++, p=0, no write; if p == size[h] and h==3 -> DONE, no write.
REQ-017 COPY duration SHALL be exactly (sum of clamped sizes) + 4 cycles; zero-size hulls consume one cycle each.
REQ-018 Merged order SHALL be hull1 points, then hull2, hull3, hull4, each in source slot order, with no gaps.
REQ-019 Slots at index >= mergedCloudSize SHALL read 0.
REQ-020 DONE: collectorDone=1; outputs held; collectorEnable=0 -> IDLE next cycle with collectorDone=0, mergedCloud/mergedCloudSize retained.
REQ-021 collectorEnable deassertion during WAIT_DONE or COPY SHALL be ignored; the merge completes.
REQ-022 convexHull/convexHullSize inputs SHALL be held stable by the source from first processorDone until collectorDone; behaviour otherwise undefined.
REQ-023 processorDone asserted in IDLE SHALL be ignored (flags not set).
REQ-024 mergedCloudSize SHALL never exceed 1024; wp SHALL be 10 bits plus size counter 11 bits, no wrap possible given REQ-014 clamp.

Reset
REQ-025 reset_n=0 SHALL asynchronously force state IDLE, mergedCloud=0, mergedCloudSize=0, collectorDone=0, sticky flags=0, h=p=wp=0.
REQ-026 reset_n assertion mid-COPY SHALL abandon the merge; after release the block SHALL wait in IDLE for collectorEnable.
REQ-027 reset_n release SHALL be synchronised by the system; block SHALL not act on the release edge itself.

Verification
REQ-028 Sizes 3,2,0,1, hull1 points 0x0101,0x0202,0x0303, hull2 0x1111,0x2222, hull4 0x4444, all done pulsed same cycle -> mergedCloudSize=6, slots 0..5 = 0101,0202,0303,1111,2222,4444, slot 6=0, COPY lasts 10 cycles.
REQ-029 Done pulses staggered: done1 at cycle 2, done3 at 5, done2 at 9, done4 at 20 -> COPY entered cycle 21, not earlier.
REQ-030 All sizes 256, distinct patterns -> mergedCloudSize=1024, slot 1023 = hull4 slot 255, COPY lasts 1028 cycles.
REQ-031 All sizes 0 -> mergedCloudSize=0, mergedCloud=0, collectorDone after 4 COPY cycles.
REQ-032 Size1=300 (illegal), others 0 -> clamped, mergedCloudSize=256.
REQ-033 reset_n low mid-COPY after 5 writes -> all outputs 0 immediately; re-enable with same data -> identical result to undisturbed run.

Source files
------------

// File: rtl/m_port_ultra_hull_collector.sv
`default_nettype none
// ============================================================================
// Module      : m_port_ultra_hull_collector
// Description : Waits for four quickhull processors to finish, then copies
//               their hull point lists back to back into one merged cloud.
//               Hull sizes are latched (and clamped to 256) when the copy
//               begins; one point is copied per clock, and each hull spends
//               one extra clock on its end-of-list step.
// Revision    : 1.0 - initial release
// ============================================================================
module m_port_ultra_hull_collector (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           collectorEnable,
    input  logic           processorDone1,
    input  logic           processorDone2,
    input  logic           processorDone3,
    input  logic           processorDone4,
    input  logic [4095:0]  convexHull1,
    input  logic [4095:0]  convexHull2,
    input  logic [4095:0]  convexHull3,
    input  logic [4095:0]  convexHull4,
    input  logic [8:0]     convexHullSize1,
    input  logic [8:0]     convexHullSize2,
    input  logic [8:0]     convexHullSize3,
    input  logic [8:0]     convexHullSize4,
    output logic [16383:0] mergedCloud,
    output logic [10:0]    mergedCloudSize,
    output logic           collectorDone
);

    // State encoding
    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WAIT_DONE = 2'd1;
    localparam logic [1:0] c_COPY      = 2'd2;
    localparam logic [1:0] c_DONE      = 2'd3;

    localparam logic [8:0] c_MAX_SIZE  = 9'd256;
    localparam logic [1:0] c_LAST_HULL = 2'd3;

    logic [1:0]    r_state;
    logic [3:0]    r_doneFlags;
    logic [8:0]    r_size [4];
    logic [1:0]    r_hullIdx;
    logic [8:0]    r_pointIdx;
    logic [9:0]    r_writePtr;

    logic [3:0]    w_doneNow;
    logic          w_allDone;
    logic [8:0]    w_curSize;
    logic          w_havePoint;
    logic [4095:0] w_srcHull;
    logic [15:0]   w_srcPoint;

    // Sizes above 256 are illegal; treat them as a full hull so the
    // write pointer can never run past slot 1023.
    function automatic logic [8:0] clampSize(input logic [8:0] size);
        return (size > c_MAX_SIZE) ? c_MAX_SIZE : size;
    endfunction

    assign w_doneNow   = {processorDone4, processorDone3, processorDone2, processorDone1};
    // A done arriving in the same cycle as the last missing flag still counts.
    assign w_allDone   = &(r_doneFlags | w_doneNow);
    assign w_curSize   = r_size[r_hullIdx];
    // Point index only reaches 256 on the end-of-list step, where no read occurs.
    assign w_havePoint = (r_pointIdx < w_curSize);
    assign w_srcPoint  = w_srcHull[{r_pointIdx[7:0], 4'b0000} +: 16];

    // Select the hull currently being copied
    always_comb begin
        w_srcHull = convexHull1;
        case (r_hullIdx)
            2'd0:    w_srcHull = convexHull1;
            2'd1:    w_srcHull = convexHull2;
            2'd2:    w_srcHull = convexHull3;
            default: w_srcHull = convexHull4;
        endcase
    end

    // Collector FSM with registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= c_IDLE;
            r_doneFlags     <= 4'b0000;
            r_hullIdx       <= 2'd0;
            r_pointIdx      <= 9'd0;
            r_writePtr      <= 10'd0;
            for (int i = 0; i < 4; i++) begin
                r_size[i] <= 9'd0;
            end
            mergedCloud     <= '0;
            mergedCloudSize <= 11'd0;
            collectorDone   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    // processorDone is deliberately ignored here
                    if (collectorEnable) begin
                        r_state         <= c_WAIT_DONE;
                        r_doneFlags     <= 4'b0000;
                        r_writePtr      <= 10'd0;
                        r_hullIdx       <= 2'd0;
                        r_pointIdx      <= 9'd0;
                        mergedCloud     <= '0;
                        mergedCloudSize <= 11'd0;
                    end
                end

                c_WAIT_DONE: begin
                    r_doneFlags <= r_doneFlags | w_doneNow;
                    if (w_allDone) begin
                        r_state    <= c_COPY;
                        r_size[0]  <= clampSize(convexHullSize1);
                        r_size[1]  <= clampSize(convexHullSize2);
                        r_size[2]  <= clampSize(convexHullSize3);
                        r_size[3]  <= clampSize(convexHullSize4);
                        r_hullIdx  <= 2'd0;
                        r_pointIdx <= 9'd0;
                    end
                end

                c_COPY: begin
                    if (w_havePoint) begin
                        mergedCloud[{r_writePtr, 4'b0000} +: 16] <= w_srcPoint;
                        r_writePtr      <= r_writePtr + 10'd1;
                        r_pointIdx      <= r_pointIdx + 9'd1;
                        mergedCloudSize <= mergedCloudSize + 11'd1;
                    end else if (r_hullIdx != c_LAST_HULL) begin
                        r_hullIdx  <= r_hullIdx + 2'd1;
                        r_pointIdx <= 9'd0;
                    end else begin
                        r_state       <= c_DONE;
                        collectorDone <= 1'b1;
                    end
                end

                c_DONE: begin
                    // Result is held until the requester drops enable
                    if (!collectorEnable) begin
                        r_state       <= c_IDLE;
                        collectorDone <= 1'b0;
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_m_port_ultra_hull_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_port_ultra_hull_collector
// Description : Directed self-checking bench for the hull collector. A queue
//               model of the merge produces the expected outputs cycle by
//               cycle; literal expectations pin sizes, slots and timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_port_ultra_hull_collector;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           collectorEnable;
    logic           processorDone1, processorDone2, processorDone3, processorDone4;
    logic [4095:0]  convexHull1, convexHull2, convexHull3, convexHull4;
    logic [8:0]     convexHullSize1, convexHullSize2, convexHullSize3, convexHullSize4;
    logic [16383:0] mergedCloud;
    logic [10:0]    mergedCloudSize;
    logic           collectorDone;

    always #5 clk = ~clk;

    m_port_ultra_hull_collector dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .collectorEnable (collectorEnable),
        .processorDone1  (processorDone1),
        .processorDone2  (processorDone2),
        .processorDone3  (processorDone3),
        .processorDone4  (processorDone4),
        .convexHull1     (convexHull1),
        .convexHull2     (convexHull2),
        .convexHull3     (convexHull3),
        .convexHull4     (convexHull4),
        .convexHullSize1 (convexHullSize1),
        .convexHullSize2 (convexHullSize2),
        .convexHullSize3 (convexHullSize3),
        .convexHullSize4 (convexHullSize4),
        .mergedCloud     (mergedCloud),
        .mergedCloudSize (mergedCloudSize),
        .collectorDone   (collectorDone)
    );

    // Source data as plain arrays, packed onto the buses
    logic [15:0] hullMem [4][256];
    int          sizeIn  [4];

    always_comb begin
        convexHull1 = '0;
        convexHull2 = '0;
        convexHull3 = '0;
        convexHull4 = '0;
        for (int k = 0; k < 256; k++) begin
            convexHull1[16*k +: 16] = hullMem[0][k];
            convexHull2[16*k +: 16] = hullMem[1][k];
            convexHull3[16*k +: 16] = hullMem[2][k];
            convexHull4[16*k +: 16] = hullMem[3][k];
        end
    end

    assign convexHullSize1 = 9'(sizeIn[0]);
    assign convexHullSize2 = 9'(sizeIn[1]);
    assign convexHullSize3 = 9'(sizeIn[2]);
    assign convexHullSize4 = 9'(sizeIn[3]);

    // Model state and bookkeeping
    logic [16383:0] expCloud;
    int             expSize;
    logic           expDone;
    bit             checkEn;
    int             nChecks;
    int             nPass;
    int             cyc;
    int             firstDoneCyc;
    int             firstWriteCyc;
    int             evQ[$];   // -1 = end-of-hull step, else (hull<<8)|point

    task automatic check(input string name, input longint act, input longint exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic checkCloud(input string name, input logic [16383:0] act,
                              input logic [16383:0] exp);
        int slot;
        nChecks++;
        if (act == exp) begin
            nPass++;
        end else begin
            slot = 0;
            for (int s = 0; s < 1024; s++) begin
                if (act[16*s +: 16] != exp[16*s +: 16]) begin
                    slot = s;
                    break;
                end
            end
            $display("FAIL %s: slot %0d got %04h expected %04h (t=%0t)", name, slot,
                     act[16*slot +: 16], exp[16*slot +: 16], $time);
        end
    endtask

    // Compare process: DUT outputs against the model every cycle
    always @(negedge clk) begin
        if (checkEn) begin
            check("collectorDone", longint'(collectorDone), longint'(expDone));
            check("mergedCloudSize", longint'(mergedCloudSize), longint'(expSize));
            checkCloud("mergedCloud", mergedCloud, expCloud);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (collectorDone === 1'b1 && firstDoneCyc < 0) firstDoneCyc = cyc;
        if (mergedCloudSize != 11'd0 && firstWriteCyc < 0) firstWriteCyc = cyc;
    endtask

    task automatic setDones(input logic d1, input logic d2, input logic d3, input logic d4);
        processorDone1 = d1;
        processorDone2 = d2;
        processorDone3 = d3;
        processorDone4 = d4;
    endtask

    // One merge: enable, done pulses at WAIT-relative cycles d0..d3, copy, release.
    // abortAfter >= 0 pulls reset once that many points have been written.
    task automatic runMerge(input int s0, input int s1, input int s2, input int s3,
                            input int d0, input int d1, input int d2, input int d3,
                            input bit dropEn, input bit levelDone, input int abortAfter);
        int sz [4];
        int dl [4];
        int dmax;
        int ev;
        sizeIn[0] = s0; sizeIn[1] = s1; sizeIn[2] = s2; sizeIn[3] = s3;
        dl[0] = d0; dl[1] = d1; dl[2] = d2; dl[3] = d3;
        dmax = 0;
        evQ.delete();
        for (int h = 0; h < 4; h++) begin
            sz[h] = (sizeIn[h] > 256) ? 256 : sizeIn[h];
            if (dl[h] > dmax) dmax = dl[h];
            for (int p = 0; p < sz[h]; p++) evQ.push_back((h << 8) | p);
            evQ.push_back(-1);
        end

        collectorEnable = 1'b1;
        tick();
        expCloud = '0; expSize = 0; expDone = 1'b0;
        cyc = 0; firstDoneCyc = -1; firstWriteCyc = -1;

        for (int c = 0; c <= dmax; c++) begin
            setDones((c == dl[0]) || (levelDone && c >= dl[0]),
                     (c == dl[1]) || (levelDone && c >= dl[1]),
                     (c == dl[2]) || (levelDone && c >= dl[2]),
                     (c == dl[3]) || (levelDone && c >= dl[3]));
            if (dropEn && c == 0) collectorEnable = 1'b0;
            tick();
        end
        if (!levelDone) setDones(1'b0, 1'b0, 1'b0, 1'b0);

        while (evQ.size() > 0) begin
            if (abortAfter >= 0 && expSize == abortAfter) begin
                #2;
                checkEn = 1'b0;
                reset_n = 1'b0;
                #1;
                check("abort_size", longint'(mergedCloudSize), 0);
                check("abort_done", longint'(collectorDone), 0);
                checkCloud("abort_cloud", mergedCloud, '0);
                collectorEnable = 1'b0;
                setDones(1'b0, 1'b0, 1'b0, 1'b0);
                repeat (2) @(posedge clk);
                #3;
                reset_n = 1'b1;
                expCloud = '0; expSize = 0; expDone = 1'b0;
                evQ.delete();
                checkEn = 1'b1;
                repeat (3) tick();
                return;
            end
            tick();
            ev = evQ.pop_front();
            if (ev >= 0) begin
                expCloud[16*expSize +: 16] = hullMem[ev >> 8][ev & 255];
                expSize++;
            end
            if (evQ.size() == 0) expDone = 1'b1;
        end

        for (int i = 0; i < 2; i++) begin
            tick();
            if (!collectorEnable) expDone = 1'b0;
        end
        setDones(1'b0, 1'b0, 1'b0, 1'b0);
        collectorEnable = 1'b0;
        tick();
        expDone = 1'b0;
        tick();
    endtask

    task automatic clearHulls();
        for (int h = 0; h < 4; h++)
            for (int k = 0; k < 256; k++) hullMem[h][k] = 16'h0000;
    endtask

    task automatic loadSmallSet();
        clearHulls();
        hullMem[0][0] = 16'h0101; hullMem[0][1] = 16'h0202; hullMem[0][2] = 16'h0303;
        hullMem[0][3] = 16'hDEAD;   // beyond size, must not be copied
        hullMem[1][0] = 16'h1111; hullMem[1][1] = 16'h2222;
        hullMem[2][0] = 16'h3333;   // size 0, must not be copied
        hullMem[3][0] = 16'h4444;
    endtask

    logic [15:0]    lit [7];
    logic [16383:0] snap;

    initial begin
        nChecks = 0; nPass = 0; checkEn = 1'b0;
        cyc = 0; firstDoneCyc = -1; firstWriteCyc = -1;
        reset_n = 1'b0;
        collectorEnable = 1'b0;
        setDones(1'b0, 1'b0, 1'b0, 1'b0);
        clearHulls();
        for (int h = 0; h < 4; h++) sizeIn[h] = 0;
        expCloud = '0; expSize = 0; expDone = 1'b0;

        repeat (3) @(posedge clk);
        #3;
        check("reset_size", longint'(mergedCloudSize), 0);
        check("reset_done", longint'(collectorDone), 0);
        checkCloud("reset_cloud", mergedCloud, '0);
        reset_n = 1'b1;
        checkEn = 1'b1;
        repeat (2) tick();

        // Mixed sizes 3,2,0,1, all dones in the same cycle
        loadSmallSet();
        runMerge(3, 2, 0, 1, 0, 0, 0, 0, 1'b0, 1'b0, -1);
        lit[0] = 16'h0101; lit[1] = 16'h0202; lit[2] = 16'h0303; lit[3] = 16'h1111;
        lit[4] = 16'h2222; lit[5] = 16'h4444; lit[6] = 16'h0000;
        snap = mergedCloud;
        check("small_size", longint'(mergedCloudSize), 6);
        for (int s = 0; s < 7; s++) check($sformatf("small_slot%0d", s), longint'(snap[16*s +: 16]), longint'(lit[s]));
        check("small_copy_cycles", longint'(firstDoneCyc - 1), 10);

        // Staggered dones, after stray dones in IDLE
        clearHulls();
        hullMem[0][0] = 16'hA001; hullMem[1][0] = 16'hA002;
        hullMem[2][0] = 16'hA003; hullMem[3][0] = 16'hA004;
        setDones(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        setDones(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        runMerge(1, 1, 1, 1, 2, 9, 5, 20, 1'b0, 1'b0, -1);
        check("stagger_first_write_cycle", longint'(firstWriteCyc), 22);
        check("stagger_done_cycle", longint'(firstDoneCyc), 29);

        // All hulls full with distinct points
        for (int h = 0; h < 4; h++)
            for (int k = 0; k < 256; k++) hullMem[h][k] = 16'((h + 1) * 4096 + k);
        runMerge(256, 256, 256, 256, 1, 0, 3, 2, 1'b0, 1'b0, -1);
        snap = mergedCloud;
        check("full_size", longint'(mergedCloudSize), 1024);
        check("full_slot1023", longint'(snap[16*1023 +: 16]), 64'h40FF);
        check("full_copy_cycles", longint'(firstDoneCyc - 4), 1028);

        // All sizes zero, enable dropped early, level dones
        runMerge(0, 0, 0, 0, 1, 3, 2, 0, 1'b1, 1'b1, -1);
        check("zero_size", longint'(mergedCloudSize), 0);
        check("zero_copy_cycles", longint'(firstDoneCyc - 4), 4);

        // Oversized hull 1 is clamped
        runMerge(300, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, -1);
        check("clamp_size", longint'(mergedCloudSize), 256);
        check("clamp_done_cycle", longint'(firstDoneCyc), 1 + 256 + 4);

        // Reset mid-copy, then rerun on the same data
        loadSmallSet();
        runMerge(3, 2, 0, 1, 0, 0, 0, 0, 1'b0, 1'b0, 5);
        runMerge(3, 2, 0, 1, 0, 0, 0, 0, 1'b0, 1'b0, -1);
        snap = mergedCloud;
        check("rerun_size", longint'(mergedCloudSize), 6);
        check("rerun_slot5", longint'(snap[16*5 +: 16]), 64'h4444);
        check("rerun_slot6", longint'(snap[16*6 +: 16]), 0);

        checkEn = 1'b0;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
